mfp_multi_digit_seven_segment_display: RTL

MFP_MULTI_DIGIT_SEVEN_SEGMENT_DISPLAY -- requirements
Module: mfp_multi_digit_seven_segment_display

---
 rtl/mfp_multi_digit_seven_segment_display.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mfp_multi_digit_seven_segment_display.sv
// Multi-digit hex seven-segment driver: shadowed inputs, static per-digit outputs,
// and a time-multiplexed scan port with leading-zero blanking and per-digit blink.
module mfp_multi_digit_seven_segment_display #(
  parameter int N_DIGITS       = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] number,
  input  logic [N_DIGITS-1:0]   dots,
  input  logic [N_DIGITS-1:0]   blink,
  input  logic                  blank_lz,
  input  logic                  load,
  output logic [7*N_DIGITS-1:0] seg_static,
  output logic [N_DIGITS-1:0]   dp_static,
  output logic [6:0]            seg_scan,
  output logic                  dp_scan,
  output logic [N_DIGITS-1:0]   anode,
  output logic                  frame_done
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [7*N_DIGITS-1:0] SEG_ST_INV = {(7*N_DIGITS){SEG_ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0]   DP_ST_INV  = {N_DIGITS{SEG_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_SC_INV = {7{SEG_ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0]   AN_INV     = {N_DIGITS{AN_ACTIVE_LOW}};

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [4*N_DIGITS-1:0] num_q, num_d;
  logic [N_DIGITS-1:0]   dots_q, dots_d, blink_q, blink_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frm_q, frm_d;
  logic                  phase_q, phase_d;
  logic                  frame_done_q, frame_done_d;
  logic [7*N_DIGITS-1:0] seg_static_q, seg_static_d;
  logic [N_DIGITS-1:0]   dp_static_q, dp_static_d;
  logic [6:0]            seg_scan_q, seg_scan_d;
  logic                  dp_scan_q, dp_scan_d;
  logic [N_DIGITS-1:0]   anode_q, anode_d;

  logic                  tick, wrap;
  logic                  hi_zero_run;
  logic [N_DIGITS-1:0]   blank;
  logic [7*N_DIGITS-1:0] seg_act;
  logic [N_DIGITS-1:0]   dp_act;
  logic [6:0]            seg_sel;
  logic                  dp_sel;
  logic [N_DIGITS-1:0]   an_sel;

  assign tick = (presc_q == PW'(SCAN_DIV - 1));
  assign wrap = tick && (idx_q == IW'(N_DIGITS - 1));

  always_comb begin
    num_d   = num_q;
    dots_d  = dots_q;
    blink_d = blink_q;
    if (load) begin
      num_d   = number;
      dots_d  = dots;
      blink_d = blink;
    end

    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (wrap)      idx_d = '0;
    else if (tick) idx_d = idx_q + IW'(1);

    frm_d   = frm_q;
    phase_d = phase_q;
    if (wrap) begin
      if (frm_q == FW'(BLINK_FRAMES - 1)) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FW'(1);
      end
    end
    frame_done_d = wrap;
  end

  // Walk from the top digit down so hi_zero_run means "this digit and all above are 0".
  always_comb begin
    hi_zero_run = 1'b1;
    blank       = '0;
    seg_act     = '0;
    dp_act      = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      hi_zero_run = hi_zero_run && (num_q[4*i +: 4] == 4'h0);
      blank[i]    = (blank_lz && (i > 0) && hi_zero_run) || (blink_q[i] && phase_q);
      seg_act[7*i +: 7] = blank[i] ? 7'h00 : hex7(num_q[4*i +: 4]);
      dp_act[i]   = dots_q[i] && !blank[i];
    end
  end

  always_comb begin
    seg_sel = '0;
    dp_sel  = 1'b0;
    an_sel  = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        seg_sel   = seg_act[7*i +: 7];
        dp_sel    = dp_act[i];
        an_sel[i] = 1'b1;
      end
    end
    seg_static_d = seg_act ^ SEG_ST_INV;
    dp_static_d  = dp_act ^ DP_ST_INV;
    seg_scan_d   = seg_sel ^ SEG_SC_INV;
    dp_scan_d    = dp_sel ^ SEG_ACTIVE_LOW;
    anode_d      = an_sel ^ AN_INV;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q        <= '0;
      dots_q       <= '0;
      blink_q      <= '0;
      presc_q      <= '0;
      idx_q        <= '0;
      frm_q        <= '0;
      phase_q      <= 1'b0;
      frame_done_q <= 1'b0;
      seg_static_q <= SEG_ST_INV;
      dp_static_q  <= DP_ST_INV;
      seg_scan_q   <= SEG_SC_INV;
      dp_scan_q    <= SEG_ACTIVE_LOW;
      anode_q      <= AN_INV;
    end else begin
      num_q        <= num_d;
      dots_q       <= dots_d;
      blink_q      <= blink_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      frm_q        <= frm_d;
      phase_q      <= phase_d;
      frame_done_q <= frame_done_d;
      seg_static_q <= seg_static_d;
      dp_static_q  <= dp_static_d;
      seg_scan_q   <= seg_scan_d;
      dp_scan_q    <= dp_scan_d;
      anode_q      <= anode_d;
    end
  end

  assign seg_static = seg_static_q;
  assign dp_static  = dp_static_q;
  assign seg_scan   = seg_scan_q;
  assign dp_scan    = dp_scan_q;
  assign anode      = anode_q;
  assign frame_done = frame_done_q;

endmodule
